// File: rtl/uart_tx_buffer_pkg.sv
// Shared constants for the UART transmit buffer: default geometry and the
// 2-bit drain FSM state encoding.
package uart_tx_buffer_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with an explicit occupancy counter. A write while full
// is accepted only when a pop happens in the same cycle.
module sync_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr];
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Queues bytes stored by the CPU and hands them one at a time to the UART
// sender, waiting for each busy period to start and finish before the next.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     clr_ovf,
    input  logic                     TX_STATUS,
    output logic                     TX_EN,
    output logic [WIDTH-1:0]         TX_DATA,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               fsm_state
);

    logic [1:0]       state;
    logic             tx_en_q;
    logic [WIDTH-1:0] tx_data_q;
    logic             ovf_q;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] head;

    // The head is popped during the LAUNCH cycle, so a full-FIFO write there is kept.
    assign pop  = (state == ST_LAUNCH);
    assign drop = wr_en && full && !pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty && TX_STATUS) begin
                        state     <= ST_LAUNCH;
                        tx_en_q   <= 1'b1;
                        tx_data_q <= head;
                    end
                end
                ST_LAUNCH:    state <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: if (!TX_STATUS) state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (TX_STATUS)  state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // A dropped write wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset)       ovf_q <= 1'b0;
        else if (drop)    ovf_q <= 1'b1;
        else if (clr_ovf) ovf_q <= 1'b0;
    end

    assign TX_EN     = tx_en_q;
    assign TX_DATA   = tx_data_q;
    assign overflow  = ovf_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: a queue-based model checked every cycle, a
// 10-cycle busy sender model, and directed scenarios with literal expectations.
module tb_uart_tx_buffer;
    import uart_tx_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int BUSY  = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             clr_ovf = 1'b0;
    logic             hold = 1'b0;
    logic             tx_status;
    logic             tx_en;
    logic [WIDTH-1:0] tx_data;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;
    logic [1:0]       fsm_state;

    int busy_cnt = 0;
    assign tx_status = (busy_cnt == 0) && !hold;

    uart_tx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_ovf   (clr_ovf),
        .TX_STATUS (tx_status),
        .TX_EN     (tx_en),
        .TX_DATA   (tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail = 0;
    longint cycle = 0;
    longint last_launch = -1;
    int     launches = 0;
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_q[$];
    bit               m_tx_en = 0;
    logic [WIDTH-1:0] m_tx_data = '0;
    bit               m_ovf = 0;
    bit               m_engaged = 0;
    bit               m_saw_busy = 0;
    bit               m_pop, m_drop, m_had;
    logic [WIDTH-1:0] m_head;

    always @(posedge clk) begin
        cycle++;
        if (!reset) begin
            m_q.delete();
            m_tx_en = 0; m_tx_data = '0; m_ovf = 0; m_engaged = 0; m_saw_busy = 0;
        end else begin
            m_had  = (m_q.size() > 0);
            m_head = m_had ? m_q[0] : '0;
            m_pop  = m_tx_en;
            m_drop = wr_en && (m_q.size() == DEPTH) && !m_pop;
            if (m_pop) void'(m_q.pop_front());
            if (wr_en && !m_drop) m_q.push_back(wr_data);
            if (m_drop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            if (m_pop) begin
                m_tx_en = 0;
                m_saw_busy = 0;
            end else if (m_engaged) begin
                if (!m_saw_busy) begin
                    if (!tx_status) m_saw_busy = 1;
                end else if (tx_status) begin
                    m_engaged = 0;
                end
            end else if (m_had && tx_status) begin
                m_tx_en = 1;
                m_tx_data = m_head;
                m_engaged = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cycle > 0) begin
            check("tx_en", tx_en, m_tx_en);
            check("tx_data", tx_data, m_tx_data);
            check("count", count, m_q.size());
            check("full", full, m_q.size() == DEPTH);
            check("empty", empty, m_q.size() == 0);
            check("overflow", overflow, m_ovf);
        end
    end

    // Launch monitor and sender busy model.
    always @(negedge clk) begin
        if (tx_en) begin
            got_q.push_back(tx_data);
            launches++;
            if (last_launch >= 0) check("tx_spacing", (cycle - last_launch) >= BUSY + 2, 1);
            last_launch = cycle;
            busy_cnt = BUSY;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write(input logic [WIDTH-1:0] d);
        wr_data = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_emitted(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("emit_count", got_q.size(), n);
    endtask

    task automatic wait_launch(input int budget);
        int k = 0;
        while (!tx_en && k < budget) begin
            tick();
            k++;
        end
        check("launch_seen", tx_en, 1);
    endtask

    task automatic compare_seq(input string name);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (2) tick();
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", fsm_state, ST_IDLE);
        reset = 1'b1;
        tick();

        // Single byte: TX_EN two cycles after the write
        write(8'h41);
        check("single_cnt", count, 1);
        check("single_no_en", tx_en, 0);
        tick();
        check("single_en", tx_en, 1);
        check("single_data", tx_data, 8'h41);
        tick();
        check("single_empty", empty, 1);
        check("single_en_low", tx_en, 0);
        exp_q.push_back(8'h41);
        wait_emitted(1, 5);
        compare_seq("single_seq");
        repeat (15) tick();

        // Burst while the sender is busy
        hold = 1'b1;
        for (int i = 0; i < 8; i++) write(8'(i));
        check("burst_full", full, 1);
        check("burst_count", count, 8);
        hold = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        wait_emitted(8, 200);
        compare_seq("burst_seq");
        repeat (15) tick();

        // Overflow, clear, and clear colliding with a drop
        hold = 1'b1;
        for (int i = 0; i < 8; i++) write(8'h20 + 8'(i));
        write(8'hFF);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 8);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);
        wr_data = 8'hFE; wr_en = 1'b1; clr_ovf = 1'b1;
        tick();
        wr_en = 1'b0; clr_ovf = 1'b0;
        check("ovf_collide", overflow, 1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("ovf_clr2", overflow, 0);
        hold = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h20 + 8'(i));
        wait_emitted(8, 200);
        compare_seq("ovf_seq");
        repeat (15) tick();

        // Full plus pop: write in the LAUNCH cycle
        hold = 1'b1;
        for (int i = 0; i < 8; i++) write(8'h10 + 8'(i));
        hold = 1'b0;
        wait_launch(10);
        write(8'hAA);
        check("fp_count", count, 8);
        check("fp_no_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
        exp_q.push_back(8'hAA);
        wait_emitted(9, 250);
        compare_seq("fp_seq");
        repeat (15) tick();

        // Wrap: 20 writes interleaved with draining
        for (int i = 0; i < 20; i++) begin
            write(8'h60 + 8'(i));
            exp_q.push_back(8'h60 + 8'(i));
            repeat (8) tick();
        end
        wait_emitted(20, 400);
        check("wrap_no_ovf", overflow, 0);
        compare_seq("wrap_seq");
        repeat (15) tick();

        // Reset in WAIT_DONE with three bytes still queued
        hold = 1'b1;
        for (int i = 0; i < 4; i++) write(8'h50 + 8'(i));
        hold = 1'b0;
        wait_launch(10);
        repeat (5) tick();
        check("mid_state", fsm_state, ST_WAIT_DONE);
        check("mid_count", count, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_state", fsm_state, ST_IDLE);
        begin
            int n_before;
            n_before = launches;
            repeat (40) tick();
            check("mid_no_launch", launches, n_before);
        end
        exp_q.push_back(8'h50);
        compare_seq("mid_seq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
